// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM encoding and
// helpers that turn clock frequency and hold time into counter terminal/width.
package key_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } key_fsm_e;

  function automatic int calc_debounce_cyc(input int clk_freq, input int debounce_ms);
    return (clk_freq / 1000) * debounce_ms;
  endfunction

  // A one-cycle hold still needs a 1-bit counter to keep the port width legal.
  function automatic int calc_cnt_w(input int debounce_cyc);
    return (debounce_cyc < 2) ? 1 : $clog2(debounce_cyc);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, hold counter and a 4-state FSM
// producing a registered level plus single-cycle press/release pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 5,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_lvl;
  key_fsm_e         r_state;
  key_fsm_e         w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_key_state;
  logic             w_key_state_next;
  logic             r_press;
  logic             w_press_next;
  logic             r_release;
  logic             w_release_next;

  // Synchroniser resets to the released level so a held key is re-debounced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lvl = ~r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_state <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_key_state <= w_key_state_next;
      r_press     <= w_press_next;
      r_release   <= w_release_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_key_state_next = r_key_state;
    w_press_next     = 1'b0;
    w_release_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_lvl) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_lvl) begin
          w_state_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next     = PRESSED;
          w_press_next     = 1'b1;
          w_key_state_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        // Counter is left untouched here, so a long hold cannot wrap it.
        if (!w_lvl) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_lvl) begin
          w_state_next = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next     = IDLE;
          w_release_next   = 1'b1;
          w_key_state_next = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  assign key_state   = r_key_state;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for NUM_KEYS active-low push-buttons; every key runs through its
// own independent channel, so simultaneous events give simultaneous pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int DEBOUNCE_CYC = calc_debounce_cyc(CLK_FREQ, DEBOUNCE_MS);
  localparam int CNT_W        = calc_cnt_w(DEBOUNCE_CYC);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_debounce_ch #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n[gi]),
        .key_state  (key_state[gi]),
        .key_press  (key_press[gi]),
        .key_release(key_release[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios with fixed timing
// plus a randomized run compared against a run-length reference model.
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int CYC = 5;
  localparam int LAT = CYC + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS   (NK),
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  // Reference: a new level is accepted once the synchronised sample has
  // differed from the accepted level for CYC+1 consecutive clocks.
  logic [NK-1:0] m_s1, m_s2, m_state, m_press, m_rel;
  int            m_streak [NK];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1    <= '1;
      m_s2    <= '1;
      m_state <= '0;
      m_press <= '0;
      m_rel   <= '0;
      for (int k = 0; k < NK; k++) m_streak[k] <= 0;
    end else begin
      m_s1 <= key_n;
      m_s2 <= m_s1;
      for (int k = 0; k < NK; k++) begin
        m_press[k] <= 1'b0;
        m_rel[k]   <= 1'b0;
        if (~m_s2[k] != m_state[k]) begin
          if (m_streak[k] == CYC) begin
            m_state[k]  <= ~m_s2[k];
            m_press[k]  <= ~m_s2[k];
            m_rel[k]    <= m_s2[k];
            m_streak[k] <= 0;
          end else begin
            m_streak[k] <= m_streak[k] + 1;
          end
        end else begin
          m_streak[k] <= 0;
        end
      end
    end
  end

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [NK-1:0] exp_v;
    rst   = 1'b1;
    key_n = '0;
    repeat (3) begin
      advance();
      checks++;
      if ({key_state, key_press, key_release} !== 12'h000) begin
        failures++;
        $display("FAIL reset_outputs state=%b press=%b release=%b required all 0", key_state, key_press, key_release);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      advance();
      exp_v = (i == LAT) ? 4'b1111 : 4'b0000;
      checks++;
      if (key_press !== exp_v) begin
        failures++;
        $display("FAIL reset_held_press cycle=%0d got=%b required=%b", i, key_press, exp_v);
      end
    end
    checks++;
    if (key_state !== 4'b1111) begin
      failures++;
      $display("FAIL reset_held_state got=%b required=1111", key_state);
    end
    key_n = '1;
    for (int i = 1; i <= LAT + 2; i++) begin
      advance();
      exp_v = (i == LAT) ? 4'b1111 : 4'b0000;
      checks++;
      if (key_release !== exp_v || key_press !== 4'b0000) begin
        failures++;
        $display("FAIL reset_release cycle=%0d release=%b press=%b required release=%b press=0000", i, key_release, key_press, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_p, exp_s;
    key_n[0] = 1'b0;
    for (int i = 1; i <= LAT + 100; i++) begin
      advance();
      exp_p = (i == LAT);
      exp_s = (i >= LAT);
      checks++;
      if (key_press[0] !== exp_p || key_state[0] !== exp_s) begin
        failures++;
        $display("FAIL clean_press cycle=%0d press=%b state=%b required press=%b state=%b", i, key_press[0], key_state[0], exp_p, exp_s);
      end
    end
  endtask

  task automatic test_bounce();
    logic exp_p;
    for (int j = 0; j < 4; j++) begin
      key_n[1] = (j % 2 == 1);
      repeat (2) begin
        advance();
        checks++;
        if (key_press[1] !== 1'b0 || key_state[1] !== 1'b0) begin
          failures++;
          $display("FAIL bounce_quiet press=%b state=%b required 0/0", key_press[1], key_state[1]);
        end
      end
    end
    key_n[1] = 1'b0;
    for (int i = 1; i <= LAT + 4; i++) begin
      advance();
      exp_p = (i == LAT);
      checks++;
      if (key_press[1] !== exp_p) begin
        failures++;
        $display("FAIL bounce_press cycle=%0d got=%b required=%b", i, key_press[1], exp_p);
      end
    end
    key_n[1] = 1'b1;
    for (int i = 1; i <= LAT + 2; i++) begin
      advance();
      exp_p = (i == LAT);
      checks++;
      if (key_release[1] !== exp_p || key_state[1] !== (i < LAT)) begin
        failures++;
        $display("FAIL bounce_release cycle=%0d release=%b state=%b required release=%b", i, key_release[1], key_state[1], exp_p);
      end
    end
  endtask

  task automatic test_glitch();
    key_n[2] = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      advance();
      if (i == 3) key_n[2] = 1'b1;
      checks++;
      if (key_press[2] !== 1'b0 || key_state[2] !== 1'b0 || key_release[2] !== 1'b0) begin
        failures++;
        $display("FAIL glitch cycle=%0d press=%b state=%b release=%b required 0/0/0", i, key_press[2], key_state[2], key_release[2]);
      end
    end
  endtask

  task automatic test_back_to_back_release();
    logic [NK-1:0] exp_v;
    key_n[3] = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      advance();
      checks++;
      if (key_press[3] !== (i == LAT)) begin
        failures++;
        $display("FAIL simul_press3 cycle=%0d got=%b required=%b", i, key_press[3], (i == LAT));
      end
    end
    checks++;
    if (key_state !== 4'b1001) begin
      failures++;
      $display("FAIL simul_state_before got=%b required=1001", key_state);
    end
    key_n[0] = 1'b1;
    key_n[3] = 1'b1;
    for (int i = 1; i <= LAT + 2; i++) begin
      advance();
      exp_v = (i == LAT) ? 4'b1001 : 4'b0000;
      checks++;
      if (key_release !== exp_v) begin
        failures++;
        $display("FAIL simul_release cycle=%0d got=%b required=%b", i, key_release, exp_v);
      end
    end
    checks++;
    if (key_state !== 4'b0000) begin
      failures++;
      $display("FAIL simul_state_after got=%b required=0000", key_state);
    end
  endtask

  task automatic test_reset_mid_wait();
    key_n[0] = 1'b0;
    repeat (4) begin
      advance();
      checks++;
      if (key_press !== 4'b0000) begin
        failures++;
        $display("FAIL midreset_pre got=%b required=0000", key_press);
      end
    end
    rst = 1'b1;
    repeat (2) begin
      advance();
      checks++;
      if ({key_state, key_press, key_release} !== 12'h000) begin
        failures++;
        $display("FAIL midreset_hold state=%b press=%b release=%b required all 0", key_state, key_press, key_release);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      advance();
      checks++;
      if (key_press[0] !== (i == LAT) || key_state[0] !== (i >= LAT)) begin
        failures++;
        $display("FAIL midreset_repress cycle=%0d press=%b state=%b required press=%b", i, key_press[0], key_state[0], (i == LAT));
      end
    end
    key_n = '1;
    repeat (LAT + 2) advance();
    checks++;
    if (key_state !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_cleanup got=%b required=0000", key_state);
    end
  endtask

  task automatic test_random();
    int flip_range;
    for (int c = 0; c < 2400; c++) begin
      flip_range = (c < 600) ? 2 : 11;
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(flip_range) == 0) key_n[k] = ~key_n[k];
      end
      if (c == 1200) rst = 1'b1;
      if (c == 1203) rst = 1'b0;
      advance();
      checks++;
      if (key_state !== m_state || key_press !== m_press || key_release !== m_rel) begin
        failures++;
        $display("FAIL random cycle=%0d state=%b press=%b release=%b required state=%b press=%b release=%b",
                 c, key_state, key_press, key_release, m_state, m_press, m_rel);
      end
      checks++;
      if ((key_press & key_release) !== 4'b0000) begin
        failures++;
        $display("FAIL random_overlap cycle=%0d press=%b release=%b required no overlap", c, key_press, key_release);
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    key_n = '1;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_back_to_back_release();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
